// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Purpose : groups the boot byte stream (valid/ready handshake) and the
//           instruction memory byte write port used by imem_loader.
// Signals : byte_in/byte_valid/byte_ready - byte stream from the boot source
//           mem_we/mem_addr/mem_wdata     - byte write port to the memory
// Modports: slave  - the loader (consumes bytes, drives the memory port)
//           master - the surroundings (byte source plus memory observer)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Purpose : boot-time writer for the big-endian, byte-addressed instruction
//           memory. Streams bytes into consecutive addresses starting at
//           BASE_ADDR, holds the CPU in reset while loading, and reports
//           completion, overflow and an XOR checksum of the loaded words.
// Ports   : clk        - system clock, rising edge
//           rst_n      - asynchronous active-low reset
//           start      - begin a load (only honoured in IDLE)
//           word_count - number of 32-bit words, latched on start
//           bus        - byte stream handshake + memory byte write port
//           cpu_hold   - hold PC/fetch in reset while not IDLE
//           busy       - load in progress
//           done       - one-cycle pulse in the FINISH cycle
//           error      - sticky overflow flag, cleared by the next start
//           checksum   - XOR of all complete words loaded since start
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-2:0] word_count,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FINISH
  } state_t;

  localparam logic [ADDR_W:0] FIRST_ADDR = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] LAST_ADDR  = (ADDR_W+1)'(MEM_BYTES - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   addr;
  logic [ADDR_W:0]   bytes_left;
  logic [23:0]       word;
  logic [31:0]       word_next;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              byte_ready;
  logic              start_ok;
  logic              xfer;
  logic              last_byte;
  logic              at_end;

  // The address is one bit wider than the memory port so it can never wrap
  // back onto low memory; the load stops at LAST_ADDR before it matters.
  assign start_ok  = (state == IDLE) && start;
  assign xfer      = byte_ready && bus.byte_valid;
  assign last_byte = (bytes_left == (ADDR_W+1)'(1));
  assign at_end    = (addr == LAST_ADDR);

  // Only the three most recent bytes need storing: the oldest byte of the
  // 32-bit word would shift out on the very transfer that completes it,
  // so the full word is formed combinationally from the stored bytes plus
  // the byte arriving now (first byte ends up in bits [31:24]).
  assign word_next = {word, bus.byte_in};

  assign bus.byte_ready = byte_ready;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and state-decoded outputs. A load ends either on its last
  // byte or when the top of memory is reached; FINISH always lasts one cycle
  // and ignores start so a held start cannot retrigger a load.
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    cpu_hold   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (word_count == '0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        if (xfer && (last_byte || at_end)) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: address/count bookkeeping, word assembly, checksum, overflow
  // flag and the registered memory write port. The write lands the cycle
  // after the transfer, so the final write coincides with FINISH. Because
  // BASE_ADDR is word aligned, address bits [1:0] == 3 marks the fourth
  // byte of a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      bytes_left <= '0;
      word       <= '0;
      checksum   <= '0;
      error      <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we <= xfer;
      if (start_ok) begin
        addr       <= FIRST_ADDR;
        bytes_left <= {word_count, 2'b00};
        word       <= '0;
        checksum   <= '0;
        error      <= 1'b0;
      end else if (xfer) begin
        addr       <= addr + 1'b1;
        bytes_left <= bytes_left - 1'b1;
        word       <= word_next[23:0];
        mem_addr   <= addr[ADDR_W-1:0];
        mem_wdata  <= bus.byte_in;
        if (addr[1:0] == 2'b11) begin
          checksum <= checksum ^ word_next;
        end
        if (at_end && !last_byte) begin
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Purpose : self-checking bench for imem_loader. Two instances are used: a
//           full-size 1 KiB memory and a 16-byte memory for overflow cases.
//           Expected results come from the byte list offered to the loader:
//           bytes land at consecutive addresses, the checksum is the XOR of
//           the complete big-endian words, and loads longer than the memory
//           are truncated and flagged.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start_a;
  logic        start_b;
  logic [8:0]  wc_a;
  logic [2:0]  wc_b;
  logic [7:0]  drv_byte;
  logic        drv_valid;
  logic        sel;

  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic        error_a, error_b;
  logic        hold_a, hold_b;
  logic [31:0] checksum_a, checksum_b;

  logic        cur_ready, cur_we, cur_busy, cur_hold, cur_done, cur_error;
  logic [9:0]  cur_addr;
  logic [7:0]  cur_wdata;
  logic [31:0] cur_checksum;
  logic [31:0] cur_status;

  int          errors;
  int          checks;
  int          done_total;
  int          done_we_total;
  int          busy_total;
  int          hold_bad_total;
  logic [9:0]  log_addr[$];
  logic [7:0]  log_data[$];
  logic [7:0]  src_q[$];

  imem_loader_if #(.ADDR_W(10)) bus_a ();
  imem_loader_if #(.ADDR_W(4))  bus_b ();

  assign bus_a.byte_in    = drv_byte;
  assign bus_a.byte_valid = drv_valid;
  assign bus_b.byte_in    = drv_byte;
  assign bus_b.byte_valid = drv_valid;

  imem_loader #(.MEM_BYTES(1024), .ADDR_W(10), .BASE_ADDR(0)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .word_count (wc_a),
    .bus        (bus_a.slave),
    .cpu_hold   (hold_a),
    .busy       (busy_a),
    .done       (done_a),
    .error      (error_a),
    .checksum   (checksum_a)
  );

  imem_loader #(.MEM_BYTES(16), .ADDR_W(4), .BASE_ADDR(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .word_count (wc_b),
    .bus        (bus_b.slave),
    .cpu_hold   (hold_b),
    .busy       (busy_b),
    .done       (done_b),
    .error      (error_b),
    .checksum   (checksum_b)
  );

  // The instance under test is chosen by sel; everything the checks look at
  // goes through these muxes so one set of tasks serves both instances.
  assign cur_ready    = sel ? bus_b.byte_ready : bus_a.byte_ready;
  assign cur_we       = sel ? bus_b.mem_we     : bus_a.mem_we;
  assign cur_addr     = sel ? {6'd0, bus_b.mem_addr} : bus_a.mem_addr;
  assign cur_wdata    = sel ? bus_b.mem_wdata  : bus_a.mem_wdata;
  assign cur_busy     = sel ? busy_b     : busy_a;
  assign cur_hold     = sel ? hold_b     : hold_a;
  assign cur_done     = sel ? done_b     : done_a;
  assign cur_error    = sel ? error_b    : error_a;
  assign cur_checksum = sel ? checksum_b : checksum_a;
  assign cur_status   = {8'd0, cur_ready, cur_we, cur_busy, cur_hold,
                         cur_done, cur_error, cur_wdata, cur_addr};

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observer on the falling edge, well away from the active edge: logs every
  // memory write, counts DONE pulses (and whether each came with a write),
  // busy cycles, and any cycle where CPU hold disagrees with busy.
  always @(negedge clk) begin
    if (cur_we) begin
      log_addr.push_back(cur_addr);
      log_data.push_back(cur_wdata);
    end
    if (cur_done) begin
      done_total <= done_total + 1;
      if (cur_we) begin
        done_we_total <= done_we_total + 1;
      end
    end
    if (cur_busy) begin
      busy_total <= busy_total + 1;
    end
    if (cur_hold !== cur_busy) begin
      hold_bad_total <= hold_bad_total + 1;
    end
  end

  // One comparison: counted, and reported with tag/observed/expected on failure.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Start line and word count go only to the selected instance.
  task automatic set_start(input logic value, input int wc);
    if (sel) begin
      start_b = value;
      wc_b    = 3'(wc);
    end else begin
      start_a = value;
      wc_a    = 9'(wc);
    end
  endtask

  // Runs one load on the selected instance and checks it against the model.
  // mode 0: byte_valid always high; 1: every other cycle; 2: random.
  // hammer keeps start asserted for the whole load. abort_after > 0 pulls
  // reset low after that many transfers instead of finishing.
  task automatic apply_stimulus(input bit use_b, input int wc, input int mode,
                                input bit hammer, input int abort_after);
    int          mem_bytes;
    int          exp_n;
    int          idx;
    int          cyc;
    int          log_base;
    int          done_base;
    int          dwe_base;
    int          busy_base;
    int          hold_base;
    int          bad;
    bit          timeout;
    bit          took;
    bit          aborted;
    bit          exp_err;
    logic [31:0] exp_ck;

    sel       = use_b;
    mem_bytes = use_b ? 16 : 1024;
    while (src_q.size() < 4 * wc) src_q.push_back(8'($urandom));
    exp_n   = (4 * wc < mem_bytes) ? 4 * wc : mem_bytes;
    exp_err = (4 * wc > mem_bytes);
    exp_ck  = '0;
    for (int w = 0; w < exp_n / 4; w++) begin
      exp_ck ^= {src_q[4*w], src_q[4*w+1], src_q[4*w+2], src_q[4*w+3]};
    end

    drv_valid = 1'b1;
    drv_byte  = 8'hEE;
    @(posedge clk);
    #1;
    log_base  = log_addr.size();
    done_base = done_total;
    dwe_base  = done_we_total;
    busy_base = busy_total;
    hold_base = hold_bad_total;

    set_start(1'b1, wc);
    @(posedge clk);
    #1;
    if (!hammer) set_start(1'b0, wc);

    idx     = 0;
    cyc     = 0;
    timeout = 1'b0;
    aborted = 1'b0;
    forever begin
      if (idx < src_q.size()) begin
        case (mode)
          0:       drv_valid = 1'b1;
          1:       drv_valid = (cyc % 2) == 0;
          default: drv_valid = $urandom_range(0, 3) != 0;
        endcase
      end else begin
        drv_valid = 1'b0;
      end
      drv_byte = drv_valid ? src_q[idx] : 8'($urandom);
      @(negedge clk);
      took = drv_valid && cur_ready;
      @(posedge clk);
      #1;
      if (took) idx++;
      cyc++;
      if (abort_after > 0 && idx == abort_after) begin
        aborted = 1'b1;
        break;
      end
      if (!cur_busy) break;
      if (cyc > 500) begin
        timeout = 1'b1;
        break;
      end
    end
    drv_valid = 1'b0;
    set_start(1'b0, wc);

    if (aborted) begin
      rst_n = 1'b0;
      #1;
      check_output("reset_outputs", cur_status, 32'd0);
      check_output("reset_checksum", cur_checksum, 32'd0);
      #3;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_no_done", 32'(done_total - done_base), 32'd0);
      check_output("reset_idle", {31'd0, cur_busy}, 32'd0);
    end else begin
      check_output("timeout", {31'd0, timeout}, 32'd0);
      check_output("transfers", 32'(idx), 32'(exp_n));
      check_output("write_count", 32'(log_addr.size() - log_base), 32'(exp_n));
      bad = 0;
      for (int i = 0; i < exp_n && log_base + i < log_addr.size(); i++) begin
        if (log_addr[log_base+i] !== 10'(i) || log_data[log_base+i] !== src_q[i]) bad++;
      end
      check_output("write_contents", 32'(bad), 32'd0);
      check_output("checksum", cur_checksum, exp_ck);
      check_output("error", {31'd0, cur_error}, {31'd0, exp_err});
      check_output("done_pulses", 32'(done_total - done_base), 32'd1);
      check_output("done_with_last_write", 32'(done_we_total - dwe_base),
                   (exp_n > 0) ? 32'd1 : 32'd0);
      check_output("idle_after", {29'd0, cur_busy, cur_hold, cur_done}, 32'd0);
      check_output("hold_vs_busy", 32'(hold_bad_total - hold_base), 32'd0);
      if (mode == 0) begin
        check_output("busy_cycles", 32'(busy_total - busy_base), 32'(exp_n + 1));
      end
    end
    src_q.delete();
  endtask

  // Directed sequence: reset values, the reference two-word load, a paced
  // load, an empty load, random loads, overflow on the small memory, an
  // exact fit, reset mid-load and start held throughout a load.
  initial begin
    errors         = 0;
    checks         = 0;
    done_total     = 0;
    done_we_total  = 0;
    busy_total     = 0;
    hold_bad_total = 0;
    sel            = 1'b0;
    start_a        = 1'b0;
    start_b        = 1'b0;
    wc_a           = '0;
    wc_b           = '0;
    drv_byte       = '0;
    drv_valid      = 1'b0;
    rst_n          = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    sel = 1'b0;
    #1;
    check_output("reset_a_status", cur_status, 32'd0);
    check_output("reset_a_checksum", cur_checksum, 32'd0);
    sel = 1'b1;
    #1;
    check_output("reset_b_status", cur_status, 32'd0);
    check_output("reset_b_checksum", cur_checksum, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] two-word load, back-to-back");
    src_q = '{8'h08, 8'h01, 8'h10, 8'h20, 8'h00, 8'h64, 8'h28, 8'h24};
    apply_stimulus(1'b0, 2, 0, 1'b0, 0);

    $display("[TB] two-word load, valid every other cycle");
    src_q = '{8'h08, 8'h01, 8'h10, 8'h20, 8'h00, 8'h64, 8'h28, 8'h24};
    apply_stimulus(1'b0, 2, 1, 1'b0, 0);

    $display("[TB] zero-word load");
    apply_stimulus(1'b0, 0, 0, 1'b0, 0);

    $display("[TB] random loads");
    for (int r = 0; r < 3; r++) begin
      apply_stimulus(1'b0, int'($urandom_range(1, 6)), 2, 1'b0, 0);
    end

    $display("[TB] overflow on 16-byte memory");
    for (int i = 0; i < 20; i++) src_q.push_back(8'($urandom));
    apply_stimulus(1'b1, 5, 0, 1'b0, 0);

    $display("[TB] follow-up load clears overflow");
    apply_stimulus(1'b1, 1, 2, 1'b0, 0);

    $display("[TB] exact fit of 16-byte memory");
    apply_stimulus(1'b1, 4, 2, 1'b0, 0);

    $display("[TB] reset after three bytes, then reload");
    apply_stimulus(1'b0, 2, 0, 1'b0, 3);
    apply_stimulus(1'b0, 2, 0, 1'b0, 0);

    $display("[TB] start held during load and finish");
    apply_stimulus(1'b0, 3, 2, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
